// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: opcodes that steer the front end and the
// hazard controller state encoding.
package mips_pkg;
  localparam logic [5:0] OP_JUMP = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  typedef logic [1:0] state_t;
  localparam state_t ST_RUN   = 2'd0;
  localparam state_t ST_HOLD  = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;
endpackage

// File: rtl/pipeline_hazard_ctrl_match.sv
// Register dependency test: one in-flight destination against the IF/ID sources.
module hazard_match #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] dest,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  output logic             hit
);
  // $zero is never a real dependency.
  assign hit = (dest != '0) && ((dest == rs) || (dest == rt));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: data stalls, memory-wait freeze and redirect
// flushes for a 5-stage MIPS pipeline, plus a saturating stall counter.
module pipeline_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int REG_W     = 5,
  parameter int BR_STAGE  = 0,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op_code,
  input  logic [REG_W-1:0] IF_ID_rs,
  input  logic [REG_W-1:0] IF_ID_rt,
  input  logic             id_uses_md,
  input  logic             branch_taken,
  input  logic             ID_EXE_mem_read,
  input  logic             ID_EXE_reg_write,
  input  logic [REG_W-1:0] ID_EXE_reg_dest,
  input  logic             EXE_MEM_mem_read,
  input  logic             EXE_MEM_reg_write,
  input  logic [REG_W-1:0] EXE_MEM_reg_dest,
  input  logic             dmem_ready,
  input  logic             md_busy,
  output logic             pc_ld,
  output logic             IF_ID_write,
  output logic             nop,
  output logic             flush,
  output logic             mem_hold,
  output logic [CNT_W-1:0] stall_count
);
  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYC - 1);

  logic m_ex, m_mem;
  hazard_match #(.REG_W(REG_W)) u_match_ex (
    .dest(ID_EXE_reg_dest), .rs(IF_ID_rs), .rt(IF_ID_rt), .hit(m_ex)
  );
  hazard_match #(.REG_W(REG_W)) u_match_mem (
    .dest(EXE_MEM_reg_dest), .rs(IF_ID_rs), .rt(IF_ID_rt), .hit(m_mem)
  );

  logic is_br, is_jump, load_use, br_hz, md_hz, data_stall, mem_wait, br_res, redirect;
  assign is_br      = (op_code == OP_BEQ) || (op_code == OP_BNE);
  assign is_jump    = (op_code == OP_JUMP);
  assign load_use   = ID_EXE_mem_read & m_ex;
  // Resolving in EX lets the normal forwarding paths cover branch operands.
  assign br_hz      = (BR_STAGE == 0) &&
                      is_br && ((ID_EXE_reg_write & m_ex) || (EXE_MEM_mem_read & m_mem));
  assign md_hz      = id_uses_md & md_busy;
  assign data_stall = load_use | br_hz | md_hz;
  assign mem_wait   = EXE_MEM_mem_read & ~dmem_ready;
  // In EX mode branch_taken is only ever raised by the branch sitting in EX.
  assign br_res     = (BR_STAGE == 0) ? (branch_taken & is_br) : branch_taken;
  assign redirect   = (is_jump | br_res) & ~data_stall;

  state_t     state, saved, eff, state_nx, saved_nx;
  logic [1:0] cnt, cnt_nx;

  // HOLD is transparent once memory answers: behave as the interrupted state.
  assign eff = (state == ST_HOLD) ? saved : state;

  always_comb begin
    pc_ld       = 1'b1;
    IF_ID_write = 1'b1;
    nop         = 1'b0;
    flush       = 1'b0;
    mem_hold    = 1'b0;
    state_nx    = ST_RUN;
    saved_nx    = saved;
    cnt_nx      = cnt;
    if (!rst) begin
      pc_ld       = 1'b0;
      IF_ID_write = 1'b0;
      nop         = 1'b1;
      flush       = 1'b1;
    end else if (mem_wait) begin
      pc_ld       = 1'b0;
      IF_ID_write = 1'b0;
      mem_hold    = 1'b1;
      state_nx    = ST_HOLD;
      saved_nx    = eff;
    end else if (eff == ST_FLUSH) begin
      flush    = 1'b1;
      cnt_nx   = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
      state_nx = (cnt <= 2'd1) ? ST_RUN : ST_FLUSH;
    end else if (data_stall) begin
      pc_ld       = 1'b0;
      IF_ID_write = 1'b0;
      nop         = 1'b1;
    end else if (redirect) begin
      flush    = 1'b1;
      cnt_nx   = FLUSH_INIT;
      state_nx = (FLUSH_CYC > 1) ? ST_FLUSH : ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_RUN;
      saved       <= ST_RUN;
      cnt         <= 2'd0;
      stall_count <= '0;
    end else begin
      state <= state_nx;
      saved <= saved_nx;
      cnt   <= cnt_nx;
      if (!pc_ld && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scenario bench for pipeline_hazard_ctrl: expected outputs are queued as each
// cycle's stimulus is applied and checked at the following falling edge.
module tb_pipeline_hazard_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, JMP = 6'b000010;
  // {pc_ld, IF_ID_write, nop, flush, mem_hold}
  localparam logic [4:0] O_RUN = 5'b11000, O_STALL = 5'b00100, O_FLUSH = 5'b11010,
                         O_MEM = 5'b00001, O_RST = 5'b00110;

  logic clk = 1'b0;
  logic rst;
  logic [5:0] op_code;
  logic [REG_W-1:0] IF_ID_rs, IF_ID_rt, ID_EXE_reg_dest, EXE_MEM_reg_dest;
  logic id_uses_md, branch_taken, ID_EXE_mem_read, ID_EXE_reg_write;
  logic EXE_MEM_mem_read, EXE_MEM_reg_write, dmem_ready, md_busy;
  logic pc_ld, IF_ID_write, nop, flush, mem_hold;
  logic [CNT_W-1:0] stall_count;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .BR_STAGE(0), .FLUSH_CYC(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
    .id_uses_md(id_uses_md), .branch_taken(branch_taken),
    .ID_EXE_mem_read(ID_EXE_mem_read), .ID_EXE_reg_write(ID_EXE_reg_write),
    .ID_EXE_reg_dest(ID_EXE_reg_dest), .EXE_MEM_mem_read(EXE_MEM_mem_read),
    .EXE_MEM_reg_write(EXE_MEM_reg_write), .EXE_MEM_reg_dest(EXE_MEM_reg_dest),
    .dmem_ready(dmem_ready), .md_busy(md_busy), .pc_ld(pc_ld), .IF_ID_write(IF_ID_write),
    .nop(nop), .flush(flush), .mem_hold(mem_hold), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] o; logic [CNT_W-1:0] sc; } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] model_sc = '0;

  task automatic idle();
    rst = 1'b1; op_code = 6'd0; IF_ID_rs = 5'd1; IF_ID_rt = 5'd2;
    id_uses_md = 1'b0; branch_taken = 1'b0; md_busy = 1'b0; dmem_ready = 1'b1;
    ID_EXE_mem_read = 1'b0; ID_EXE_reg_write = 1'b0; ID_EXE_reg_dest = 5'd0;
    EXE_MEM_mem_read = 1'b0; EXE_MEM_reg_write = 1'b0; EXE_MEM_reg_dest = 5'd0;
  endtask

  // Queue this cycle's expectation, then move to the sampling edge.
  task automatic push_wait(input logic [4:0] o);
    q.push_back('{o: o, sc: model_sc});
    @(negedge clk);
  endtask

  // Cross the rising edge and advance the stall-count model.
  task automatic adv(input logic [4:0] o);
    @(posedge clk);
    if (!rst) model_sc = '0;
    else if (!o[4] && model_sc != '1) model_sc = model_sc + 1'b1;
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      idle(); rst = 1'b0; op_code = JMP;
      push_wait(O_RST);
      e = q.pop_front();
      checks++;
      if ({pc_ld, IF_ID_write, nop, flush, mem_hold} !== e.o) begin
        errors++; $display("FAIL reset c%0d outs got %b want %b", c, {pc_ld, IF_ID_write, nop, flush, mem_hold}, e.o);
      end
      checks++;
      if (c > 0 && stall_count !== e.sc) begin
        errors++; $display("FAIL reset c%0d stall_count got %0d want %0d", c, stall_count, e.sc);
      end
      adv(e.o);
    end
  endtask

  task automatic test_load_use();
    for (int c = 0; c < 2; c++) begin
      idle();
      if (c == 0) begin ID_EXE_mem_read = 1'b1; ID_EXE_reg_dest = 5'd5; IF_ID_rs = 5'd5; end
      push_wait(c == 0 ? O_STALL : O_RUN);
      e = q.pop_front();
      checks++;
      if ({pc_ld, IF_ID_write, nop, flush, mem_hold} !== e.o) begin
        errors++; $display("FAIL load_use c%0d outs got %b want %b", c, {pc_ld, IF_ID_write, nop, flush, mem_hold}, e.o);
      end
      checks++;
      if (stall_count !== e.sc) begin
        errors++; $display("FAIL load_use c%0d stall_count got %0d want %0d", c, stall_count, e.sc);
      end
      adv(e.o);
    end
  endtask

  task automatic test_branch();
    logic [4:0] o;
    for (int c = 0; c < 8; c++) begin
      idle();
      case (c)
        0: begin op_code = BEQ; IF_ID_rt = 5'd3; ID_EXE_reg_write = 1'b1; ID_EXE_reg_dest = 5'd3; o = O_STALL; end
        1: begin op_code = BEQ; IF_ID_rt = 5'd3; EXE_MEM_mem_read = 1'b1; EXE_MEM_reg_dest = 5'd3; o = O_STALL; end
        2: begin op_code = BEQ; IF_ID_rt = 5'd3; ID_EXE_reg_write = 1'b1; ID_EXE_reg_dest = 5'd0; o = O_RUN; end
        3: begin op_code = BEQ; IF_ID_rt = 5'd3; branch_taken = 1'b1; o = O_FLUSH; end
        4: o = O_FLUSH;
        5: o = O_RUN;
        6: begin op_code = BNE; IF_ID_rs = 5'd7; ID_EXE_reg_write = 1'b1; ID_EXE_reg_dest = 5'd7;
                 branch_taken = 1'b1; o = O_STALL; end
        default: o = O_RUN;
      endcase
      push_wait(o);
      e = q.pop_front();
      checks++;
      if ({pc_ld, IF_ID_write, nop, flush, mem_hold} !== e.o) begin
        errors++; $display("FAIL branch c%0d outs got %b want %b", c, {pc_ld, IF_ID_write, nop, flush, mem_hold}, e.o);
      end
      checks++;
      if (stall_count !== e.sc) begin
        errors++; $display("FAIL branch c%0d stall_count got %0d want %0d", c, stall_count, e.sc);
      end
      adv(e.o);
    end
  endtask

  task automatic test_jump();
    logic [4:0] o;
    for (int c = 0; c < 4; c++) begin
      idle();
      if (c < 2) op_code = JMP;
      o = (c < 2) ? O_FLUSH : O_RUN;
      push_wait(o);
      e = q.pop_front();
      checks++;
      if ({pc_ld, IF_ID_write, nop, flush, mem_hold} !== e.o) begin
        errors++; $display("FAIL jump c%0d outs got %b want %b", c, {pc_ld, IF_ID_write, nop, flush, mem_hold}, e.o);
      end
      adv(e.o);
    end
  endtask

  task automatic test_mem_wait();
    logic [4:0] o;
    for (int c = 0; c < 5; c++) begin
      idle();
      if (c < 4) begin
        EXE_MEM_mem_read = 1'b1; EXE_MEM_reg_dest = 5'd9; dmem_ready = (c == 3);
        ID_EXE_mem_read = 1'b1; ID_EXE_reg_dest = 5'd5; IF_ID_rs = 5'd5;
      end
      o = (c < 3) ? O_MEM : (c == 3) ? O_STALL : O_RUN;
      push_wait(o);
      e = q.pop_front();
      checks++;
      if ({pc_ld, IF_ID_write, nop, flush, mem_hold} !== e.o) begin
        errors++; $display("FAIL mem_wait c%0d outs got %b want %b", c, {pc_ld, IF_ID_write, nop, flush, mem_hold}, e.o);
      end
      checks++;
      if (stall_count !== e.sc) begin
        errors++; $display("FAIL mem_wait c%0d stall_count got %0d want %0d", c, stall_count, e.sc);
      end
      adv(e.o);
    end
  endtask

  task automatic test_md_and_saturate();
    logic [4:0] o;
    for (int c = 0; c < 23; c++) begin
      idle();
      if (c == 0) rst = 1'b0;
      else if (c <= 20) begin id_uses_md = 1'b1; md_busy = 1'b1; end
      else id_uses_md = 1'b1;
      o = (c == 0) ? O_RST : (c <= 20) ? O_STALL : O_RUN;
      push_wait(o);
      e = q.pop_front();
      checks++;
      if ({pc_ld, IF_ID_write, nop, flush, mem_hold} !== e.o) begin
        errors++; $display("FAIL md_busy c%0d outs got %b want %b", c, {pc_ld, IF_ID_write, nop, flush, mem_hold}, e.o);
      end
      checks++;
      if (stall_count !== e.sc) begin
        errors++; $display("FAIL stall_sat c%0d stall_count got %0d want %0d", c, stall_count, e.sc);
      end
      adv(e.o);
    end
  endtask

  task automatic test_flush_interrupts();
    logic [4:0] o;
    for (int c = 0; c < 9; c++) begin
      idle();
      case (c)
        0: begin op_code = JMP; o = O_FLUSH; end
        1: begin op_code = JMP; rst = 1'b0; o = O_RST; end
        2, 3: o = O_RUN;
        4: begin op_code = JMP; o = O_FLUSH; end
        5, 6: begin EXE_MEM_mem_read = 1'b1; dmem_ready = 1'b0; o = O_MEM; end
        7: begin EXE_MEM_mem_read = 1'b1; o = O_FLUSH; end
        default: o = O_RUN;
      endcase
      push_wait(o);
      e = q.pop_front();
      checks++;
      if ({pc_ld, IF_ID_write, nop, flush, mem_hold} !== e.o) begin
        errors++; $display("FAIL flush_intr c%0d outs got %b want %b", c, {pc_ld, IF_ID_write, nop, flush, mem_hold}, e.o);
      end
      checks++;
      if (stall_count !== e.sc) begin
        errors++; $display("FAIL flush_intr c%0d stall_count got %0d want %0d", c, stall_count, e.sc);
      end
      adv(e.o);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_jump();
    test_mem_wait();
    test_md_and_saturate();
    test_flush_interrupts();
    if (q.size() != 0) begin
      errors++; $display("FAIL scoreboard leftover got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter REG_W, default 5, register-address width.
REQ-002 Parameter BR_STAGE, default 0; 0 = branches resolve in ID, 1 = branches resolve in EX.
REQ-003 Parameter FLUSH_CYC, default 1, range 1..3; cycles flush is held after a redirect.
REQ-004 Parameter CNT_W, default 16, stall-counter width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-low reset.
REQ-007 op_code  in  6  opcode of instruction in IF/ID.
REQ-008 IF_ID_rs, IF_ID_rt  in  REG_W  source registers of instruction in IF/ID.
REQ-009 id_uses_md  in  1  IF/ID instruction needs the multi-cycle mul/div unit.
REQ-010 branch_taken  in  1  resolved branch condition (BEQ equal or BNE not_equal), valid in stage BR_STAGE.
REQ-011 ID_EXE_mem_read, ID_EXE_reg_write  in  1 each; ID_EXE_reg_dest  in  REG_W.
REQ-012 EXE_MEM_mem_read, EXE_MEM_reg_write  in  1 each; EXE_MEM_reg_dest  in  REG_W.
REQ-013 dmem_ready  in  1  data memory has completed the access in MEM.
REQ-014 md_busy  in  1  mul/div unit occupied.
REQ-015 pc_ld, IF_ID_write  out  1 each  front-end enables.
REQ-016 nop  out  1  insert bubble into ID/EXE.
REQ-017 flush  out  1  clear IF/ID (and ID/EXE when BR_STAGE=1).
REQ-018 mem_hold  out  1  freeze every pipeline register up to and including EXE/MEM.
REQ-019 stall_count  out  CNT_W  number of cycles with pc_ld=0 since reset.

Function
REQ-020 A "match" against a destination SHALL require dest != 0 and dest == IF_ID_rs or IF_ID_rt.
REQ-021 load_use SHALL be ID_EXE_mem_read with an ID_EXE match.
REQ-022 With BR_STAGE=0, br_hz SHALL be (BEQ or BNE in IF/ID) with an ID_EXE_reg_write match, or with an EXE_MEM_mem_read match.
REQ-023 With BR_STAGE=1, br_hz SHALL be 0.
REQ-024 md_hz SHALL be id_uses_md and md_busy.
REQ-025 mem_wait SHALL be EXE_MEM_mem_read and not dmem_ready.
REQ-026 The FSM SHALL have states RUN, HOLD and FLUSH, with priority mem_wait > (load_use|br_hz|md_hz) > redirect.
REQ-027 In any state, mem_wait SHALL force mem_hold=1, pc_ld=0, IF_ID_write=0, nop=0 and flush=0.
REQ-028 The FSM SHALL enter or stay in HOLD while mem_wait is 1 and return to the saved state on the first cycle with dmem_ready=1.
REQ-029 In RUN or HOLD, a data stall (load_use|br_hz|md_hz) without mem_wait SHALL give pc_ld=0, IF_ID_write=0, nop=1 in the same cycle.
REQ-030 redirect SHALL be a jump (6'b000010) in IF/ID, or branch_taken with BEQ/BNE in stage BR_STAGE, with no data stall.
REQ-031 redirect SHALL assert flush in the same cycle, load a counter with FLUSH_CYC-1 and enter FLUSH when FLUSH_CYC>1.
REQ-032 In FLUSH, flush SHALL be 1, pc_ld=1 and IF_ID_write=1; the counter decrements each cycle and the FSM returns to RUN at 0.
REQ-033 A new redirect in FLUSH SHALL be ignored.
REQ-034 mem_wait in FLUSH SHALL freeze the counter.
REQ-035 In RUN with no hazard, the outputs SHALL be pc_ld=1, IF_ID_write=1, nop=0, flush=0, mem_hold=0.
REQ-036 stall_count SHALL increment on each cycle with pc_ld=0 and saturate at all-ones.

Reset
REQ-037 While rst=0 at a clock edge, the FSM SHALL go to RUN, the flush counter to 0 and stall_count to 0.
REQ-038 While rst=0, the outputs SHALL be pc_ld=0, IF_ID_write=0, nop=1, flush=1, mem_hold=0.
REQ-039 Reset mid-FLUSH or mid-HOLD SHALL abandon the operation with no residual flush.

Structure
REQ-040 Opcode constants (BEQ 6'b000100, BNE 6'b000101, JUMP 6'b000010) and the state enum SHALL live in the shared package mips_pkg.
REQ-041 One sub-module, hazard_match, SHALL compute the REQ-020 match for one destination and be instantiated twice.

Verification
REQ-042 lw $5 in ID_EXE, IF/ID rs=5 -> one cycle of pc_ld=0, nop=1; stall_count 0->1.
REQ-043 BR_STAGE=0, BEQ rt=3, add $3 in ID_EXE -> stall; then lw $3 in EXE_MEM -> stall again; ID_EXE_reg_dest=0 -> no stall.
REQ-044 FLUSH_CYC=2, jump -> flush=1 for exactly 2 cycles with pc_ld=1; a second jump during FLUSH -> no extension.
REQ-045 EXE_MEM_mem_read with dmem_ready low for 3 cycles while load_use is also present -> mem_hold=1, nop=0 for 3 cycles, then nop=1 for 1 cycle.
REQ-046 id_uses_md with md_busy high for 4 cycles -> 4 stall cycles.
REQ-047 With CNT_W=4, 20 stall cycles -> stall_count holds 15.
REQ-048 rst=0 during FLUSH -> next cycle after release is RUN, flush=0.
